// File: rtl/sdp_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sdp_fifo_ctrl_if
// Description : Bundle of the push/pop handshake, status flags and RAM
//               sequencing signals for sdp_fifo_ctrl.
//               slave  : the FIFO controller side
//               master : the user plus RAM side (drives requests, ram_dout)
// Ports       : wr_en/wr_data/rd_en (requests), rd_data (show-ahead head),
//               full/empty/almost_full/count/overflow/underflow (status),
//               ram_we/ram_waddr/ram_din/ram_raddr/ram_dout (RAM side)
// Revision    : 1.0 - initial release
// ============================================================================
interface sdp_fifo_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BASE2 = 4
);
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_en;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic [DEPTH_BASE2:0]    count;
    logic                    overflow;
    logic                    underflow;
    logic                    ram_we;
    logic [DEPTH_BASE2-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_din;
    logic [DEPTH_BASE2-1:0]  ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_dout;

    modport slave (
        input  wr_en, wr_data, rd_en, ram_dout,
        output rd_data, full, empty, almost_full, count, overflow, underflow,
               ram_we, ram_waddr, ram_din, ram_raddr
    );

    modport master (
        output wr_en, wr_data, rd_en, ram_dout,
        input  rd_data, full, empty, almost_full, count, overflow, underflow,
               ram_we, ram_waddr, ram_din, ram_raddr
    );
endinterface
`default_nettype wire

// File: rtl/sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdp_fifo_ctrl
// Description : Synchronous FIFO controller sequencing one simple-dual-port
//               RAM (one write port, asynchronous read port). Owns the
//               pointers, occupancy count and full/empty/almost-full flags.
//               Head entry is presented with zero latency (show-ahead).
// Ports       : clk, rst (synchronous, active-high)
//               bus (sdp_fifo_ctrl_if.slave): push/pop requests, status
//               flags, RAM write port and RAM read address/data.
// Config      : `define SDP_FIFO_ERR_CHECK_EN enables sticky overflow /
//               underflow flags; otherwise both are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_fifo_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_BASE2  = 4,
    parameter int AFULL_THRESH = (2 ** DEPTH_BASE2) - 2
) (
    input  logic            clk,
    input  logic            rst,
    sdp_fifo_ctrl_if.slave  bus
);

    localparam logic [DEPTH_BASE2:0]   c_depth     = {1'b1, {DEPTH_BASE2{1'b0}}};
    localparam logic [DEPTH_BASE2:0]   c_afull     = (DEPTH_BASE2 + 1)'(AFULL_THRESH);
    localparam logic [DEPTH_BASE2:0]   c_cnt_one   = (DEPTH_BASE2 + 1)'(1);
    localparam logic [DEPTH_BASE2-1:0] c_ptr_one   = DEPTH_BASE2'(1);

    logic [DEPTH_BASE2-1:0] r_wr_ptr;
    logic [DEPTH_BASE2-1:0] r_rd_ptr;
    logic [DEPTH_BASE2:0]   r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_afull;

    logic                   w_push_ok;
    logic                   w_pop_ok;
    logic [DEPTH_BASE2:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0]  w_head_data;

    // Acceptance uses the registered flags of the current cycle, so a push
    // into a full FIFO is dropped even when a pop frees a slot that cycle,
    // and a pop from an empty FIFO is ignored even with a concurrent push.
    assign w_push_ok = bus.wr_en & ~r_full;
    assign w_pop_ok  = bus.rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            // Pointers wrap by natural overflow of their DEPTH_BASE2 bits.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            r_afull <= (w_count_nxt >= c_afull);
        end
    end

    // RAM write port: write is suppressed during reset so an abandoned
    // stream cannot land a stray entry.
    assign bus.ram_we    = w_push_ok & ~rst;
    assign bus.ram_waddr = r_wr_ptr;
    assign bus.ram_din   = bus.wr_data;

    // Show-ahead read: head pointer addresses the asynchronous RAM port and
    // its data goes straight out.
    assign bus.ram_raddr = r_rd_ptr;
    assign w_head_data   = bus.ram_dout;
    assign bus.rd_data   = w_head_data;

    assign bus.full        = r_full;
    assign bus.empty       = r_empty;
    assign bus.almost_full = r_afull;
    assign bus.count       = r_count;

`ifdef SDP_FIFO_ERR_CHECK_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset; set by any request against the matching flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en && r_full && !r_overflow) begin
            $display("%m: overflow first set at time %0t", $time);
        end
        if (!rst && bus.rd_en && r_empty && !r_underflow) begin
            $display("%m: underflow first set at time %0t", $time);
        end
    end
`endif

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_fifo_ctrl
// Description : Directed self-checking bench for sdp_fifo_ctrl with a
//               behavioural async-read RAM attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_fifo_ctrl;

`ifdef SDP_FIFO_ERR_CHECK_EN
    localparam logic c_err = 1'b1;
`else
    localparam logic c_err = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    sdp_fifo_ctrl_if #(.DATA_WIDTH(32), .DEPTH_BASE2(4)) bus ();

    sdp_fifo_ctrl #(
        .DATA_WIDTH   (32),
        .DEPTH_BASE2  (4),
        .AFULL_THRESH (14)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural simple-dual-port RAM: synchronous write, async read.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_waddr] <= bus.ram_din;
        end
    end
    assign bus.ram_dout = mem[bus.ram_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] wd, input logic re);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        drive(1'b1, 32'h1234, 1'b0);
        chk("ram_we_in_rst", 64'(bus.ram_we), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_afull", 64'(bus.almost_full), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_unf", 64'(bus.underflow), 64'd0);

        // Fill with 0x0..0xF.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            chk("fill_we", 64'(bus.ram_we), 64'd1);
            chk("fill_waddr", 64'(bus.ram_waddr), 64'(i));
            tick();
            chk("fill_count", 64'(bus.count), 64'(i + 1));
            chk("fill_full", 64'(bus.full), 64'(i == 15));
            chk("fill_afull", 64'(bus.almost_full), 64'(i >= 13));
            chk("fill_empty", 64'(bus.empty), 64'd0);
        end

        // Push while full: dropped.
        drive(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_we", 64'(bus.ram_we), 64'd0);
        tick();
        chk("ovf_count", 64'(bus.count), 64'd16);
        chk("ovf_full", 64'(bus.full), 64'd1);
        chk("ovf_flag", 64'(bus.overflow), 64'(c_err));
        chk("ovf_head", 64'(bus.rd_data), 64'd0);

        // Push+pop while full: push dropped, pop proceeds.
        drive(1'b1, 32'hBEEF, 1'b1);
        chk("fullpp_we", 64'(bus.ram_we), 64'd0);
        tick();
        chk("fullpp_count", 64'(bus.count), 64'd15);
        chk("fullpp_full", 64'(bus.full), 64'd0);
        chk("fullpp_head", 64'(bus.rd_data), 64'd1);

        // Drain the rest in order.
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            chk("drain_data", 64'(bus.rd_data), 64'(i));
            chk("drain_raddr", 64'(bus.ram_raddr), 64'(i));
            tick();
            chk("drain_count", 64'(bus.count), 64'(15 - i));
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);
        chk("drain_afull", 64'(bus.almost_full), 64'd0);
        chk("pre_unf", 64'(bus.underflow), 64'd0);

        // Pop while empty: ignored.
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("unf_count", 64'(bus.count), 64'd0);
        chk("unf_empty", 64'(bus.empty), 64'd1);
        chk("unf_flag", 64'(bus.underflow), 64'(c_err));

        // Push+pop on empty: only the push lands, visible next cycle.
        drive(1'b1, 32'hA5, 1'b1);
        chk("a5_we", 64'(bus.ram_we), 64'd1);
        tick();
        chk("a5_empty", 64'(bus.empty), 64'd0);
        chk("a5_data", 64'(bus.rd_data), 64'hA5);
        chk("a5_count", 64'(bus.count), 64'd1);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        chk("a5_pop_empty", 64'(bus.empty), 64'd1);
        chk("a5_pop_count", 64'(bus.count), 64'd0);

        // Steady state at count=5 with simultaneous push+pop, pointers wrap.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'(100 + k), 1'b0);
            tick();
        end
        chk("ss_count0", 64'(bus.count), 64'd5);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'(200 + k), 1'b1);
            chk("ss_data", 64'(bus.rd_data), (k < 5) ? 64'(100 + k) : 64'(195 + k));
            tick();
            chk("ss_count", 64'(bus.count), 64'd5);
        end
        chk("ss_wptr", 64'(bus.ram_waddr), 64'd10);
        chk("ss_rptr", 64'(bus.ram_raddr), 64'd5);

        // Bring to count=9, then reset mid-stream.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(300 + k), 1'b0);
            tick();
        end
        chk("mid_count", 64'(bus.count), 64'd9);
        rst = 1'b1;
        drive(1'b1, 32'h77, 1'b0);
        chk("mid_rst_we", 64'(bus.ram_we), 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("mid_count0", 64'(bus.count), 64'd0);
        chk("mid_empty", 64'(bus.empty), 64'd1);
        chk("mid_full", 64'(bus.full), 64'd0);
        chk("mid_afull", 64'(bus.almost_full), 64'd0);
        chk("mid_ovf", 64'(bus.overflow), 64'd0);
        chk("mid_unf", 64'(bus.underflow), 64'd0);
        chk("mid_wptr", 64'(bus.ram_waddr), 64'd0);
        chk("mid_rptr", 64'(bus.ram_raddr), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
